sram_save: RTL and testbench

- Write-back counterpart of the ROM/RAM download path: copies battery-backed cartridge SRAM contents from SDRAM back into DDR3 so the HPS can persist them.
- Sits beside the download logic.
  - Download side: DDR3 -> SDRAM, DDR3 read, SDRAM write.
  - This block: SDRAM -> DDR3, SDRAM read, DDR3 write.
- Triggered by a save request. Walks up to BLOCKS SRAM regions, skips clean ones, streams each dirty region byte-by-byte.

---
 rtl/sram_save.sv | 190 +++++++++++++++++++
 tb/tb_sram_save.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_save.sv
// Copies dirty battery-backed SRAM regions from SDRAM back into DDR3, one byte per read/write handshake.
// Optional build macro SRAM_SAVE_CHECKSUM_EN appends a 16-bit additive checksum (lo, hi) after each region.
module sram_save #(
  parameter int BLOCKS = 2,
  parameter int SIZE_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     save_request,
  input  logic [BLOCKS-1:0]        blk_dirty,
  input  logic [BLOCKS*25-1:0]     blk_sdram_base,
  input  logic [BLOCKS*28-1:0]     blk_ddr3_base,
  input  logic [BLOCKS*SIZE_W-1:0] blk_size,
  output logic [24:0]              sdram_addr,
  output logic                     sdram_rd,
  input  logic [7:0]               sdram_dout,
  input  logic                     sdram_ready,
  output logic                     sdram_request,
  output logic [27:0]              ddr3_addr,
  output logic [7:0]               ddr3_din,
  output logic                     ddr3_wr,
  input  logic                     ddr3_ready,
  output logic                     ddr3_request,
  output logic [BLOCKS-1:0]        blk_clean,
  output logic                     busy,
  output logic                     done
);
  localparam int IDX_W = $clog2(BLOCKS + 1);

`ifdef SRAM_SAVE_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, SCAN, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, DONE,
                            CS_LO, CS_HI} state_t;
`else
  typedef enum logic [3:0] {IDLE, SCAN, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, DONE} state_t;
`endif

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [SIZE_W-1:0] cnt, size_r, cur_size;
  logic [24:0]       sdram_base_r, cur_sdram_base;
  logic [27:0]       ddr3_base_r, cur_ddr3_base;
  logic [7:0]        data_r;
  logic              dead, cur_dirty, at_end, last, latch, capture, step;
`ifdef SRAM_SAVE_CHECKSUM_EN
  logic [15:0]       sum_r;
  logic [1:0]        cs_phase;
`endif

  always_comb begin
    cur_dirty      = 1'b0;
    cur_sdram_base = '0;
    cur_ddr3_base  = '0;
    cur_size       = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_dirty      = blk_dirty[i];
        cur_sdram_base = blk_sdram_base[i*25 +: 25];
        cur_ddr3_base  = blk_ddr3_base[i*28 +: 28];
        cur_size       = blk_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  assign at_end = (idx == IDX_W'(BLOCKS));
  assign last   = (cnt == size_r - SIZE_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // dead is set for the cycle right after each strobe, giving the unconditional wait cycle
  always_comb begin
    state_nx = state;
    sdram_rd = 1'b0;
    ddr3_wr  = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE:    if (save_request) state_nx = SCAN;
      SCAN: begin
        if (at_end) state_nx = DONE;
        else if (cur_dirty && cur_size != '0) begin
          latch    = 1'b1;
          state_nx = RD_REQ;
        end
      end
      RD_REQ: if (sdram_ready) begin
        sdram_rd = 1'b1;
        state_nx = RD_WAIT;
      end
      RD_WAIT: if (!dead && sdram_ready) begin
        capture  = 1'b1;
        state_nx = WR_REQ;
      end
      WR_REQ: if (ddr3_ready) begin
        ddr3_wr  = 1'b1;
        state_nx = WR_WAIT;
      end
      WR_WAIT: if (!dead && ddr3_ready) begin
`ifdef SRAM_SAVE_CHECKSUM_EN
        if (cs_phase == 2'd1)      state_nx = CS_HI;
        else if (cs_phase == 2'd2) state_nx = NEXT;
        else if (last)             state_nx = CS_LO;
`else
        if (last) state_nx = NEXT;
`endif
        else begin
          step     = 1'b1;
          state_nx = RD_REQ;
        end
      end
`ifdef SRAM_SAVE_CHECKSUM_EN
      CS_LO, CS_HI: if (ddr3_ready) begin
        ddr3_wr  = 1'b1;
        state_nx = WR_WAIT;
      end
`endif
      NEXT:    state_nx = SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      cnt          <= '0;
      size_r       <= '0;
      sdram_base_r <= '0;
      ddr3_base_r  <= '0;
      data_r       <= '0;
      dead         <= 1'b0;
`ifdef SRAM_SAVE_CHECKSUM_EN
      sum_r        <= '0;
      cs_phase     <= '0;
`endif
    end else begin
      dead <= sdram_rd | ddr3_wr;
      if (state == IDLE && save_request)
        idx <= '0;
      else if (state == NEXT || (state == SCAN && !at_end && !latch))
        idx <= idx + IDX_W'(1);
      if (latch) begin
        sdram_base_r <= cur_sdram_base;
        ddr3_base_r  <= cur_ddr3_base;
        size_r       <= cur_size;
        cnt          <= '0;
      end else if (step) begin
        cnt <= cnt + SIZE_W'(1);
      end
      if (capture) data_r <= sdram_dout;
`ifdef SRAM_SAVE_CHECKSUM_EN
      if (latch)        sum_r <= '0;
      else if (capture) sum_r <= sum_r + 16'(sdram_dout);
      if (latch)                          cs_phase <= 2'd0;
      else if (state == CS_LO && ddr3_wr) cs_phase <= 2'd1;
      else if (state == CS_HI && ddr3_wr) cs_phase <= 2'd2;
`endif
    end
  end

  always_comb begin
    ddr3_addr = ddr3_base_r + 28'(cnt);
    ddr3_din  = data_r;
`ifdef SRAM_SAVE_CHECKSUM_EN
    if (state == CS_LO) begin
      ddr3_addr = ddr3_base_r + 28'(size_r);
      ddr3_din  = sum_r[7:0];
    end else if (state == CS_HI) begin
      ddr3_addr = ddr3_base_r + 28'(size_r) + 28'd1;
      ddr3_din  = sum_r[15:8];
    end
`endif
  end

  always_comb begin
    blk_clean = '0;
    for (int i = 0; i < BLOCKS; i++)
      blk_clean[i] = (state == NEXT) && (idx == IDX_W'(i));
  end

  assign sdram_addr    = sdram_base_r + 25'(cnt);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign sdram_request = !(state == IDLE || state == SCAN || state == DONE);
  assign ddr3_request  = sdram_request;

endmodule

// File: tb/tb_sram_save.sv
// Scoreboard bench for sram_save: expected DDR3 writes are queued per region and checked as the DUT writes.
module tb_sram_save;
  localparam int BLOCKS = 2;
  localparam int SIZE_W = 20;
`ifdef SRAM_SAVE_CHECKSUM_EN
  localparam int CS_EXTRA = 2;
`else
  localparam int CS_EXTRA = 0;
`endif

  typedef struct {
    logic [27:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     save_request = 1'b0;
  logic [BLOCKS-1:0]        blk_dirty = '0;
  logic [BLOCKS*25-1:0]     blk_sdram_base = '0;
  logic [BLOCKS*28-1:0]     blk_ddr3_base = '0;
  logic [BLOCKS*SIZE_W-1:0] blk_size = '0;
  logic [24:0]              sdram_addr;
  logic                     sdram_rd;
  logic [7:0]               sdram_dout = '0;
  logic                     sdram_ready = 1'b1;
  logic                     sdram_request;
  logic [27:0]              ddr3_addr;
  logic [7:0]               ddr3_din;
  logic                     ddr3_wr;
  logic                     ddr3_ready = 1'b1;
  logic                     ddr3_request;
  logic [BLOCKS-1:0]        blk_clean;
  logic                     busy;
  logic                     done;

  int tests = 0;
  int fails = 0;
  int wr_count, rd_count, done_count, clean_pulses;
  logic [BLOCKS-1:0] clean_acc;
  bit req_seen, prev_wr, prev_rd, ok;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [7:0] smem [logic [24:0]];

  always #5 clk = ~clk;

  sram_save #(.BLOCKS(BLOCKS), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .reset(reset), .save_request(save_request),
    .blk_dirty(blk_dirty), .blk_sdram_base(blk_sdram_base),
    .blk_ddr3_base(blk_ddr3_base), .blk_size(blk_size),
    .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_dout(sdram_dout),
    .sdram_ready(sdram_ready), .sdram_request(sdram_request),
    .ddr3_addr(ddr3_addr), .ddr3_din(ddr3_din), .ddr3_wr(ddr3_wr),
    .ddr3_ready(ddr3_ready), .ddr3_request(ddr3_request),
    .blk_clean(blk_clean), .busy(busy), .done(done)
  );

  function automatic logic [7:0] sbyte(input logic [24:0] a);
    if (smem.exists(a)) return smem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // SDRAM model: data for a read is valid from the cycle after the strobe
  always @(posedge clk) if (sdram_rd) sdram_dout <= sbyte(sdram_addr);

  always @(negedge clk) begin
    if (ddr3_wr) begin
      wr_count++;
      tests++;
      ok = 1'b1;
      if (exp_q.size() == 0) begin
        ok = 1'b0;
        $display("FAIL wr_unexpected: got addr=%h din=%h, expected no write", ddr3_addr, ddr3_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (ddr3_addr !== mon_e.addr || ddr3_din !== mon_e.data) begin
          ok = 1'b0;
          $display("FAIL wr_data: got addr=%h din=%h, expected addr=%h din=%h",
                   ddr3_addr, ddr3_din, mon_e.addr, mon_e.data);
        end
      end
      if (!ddr3_ready || prev_wr) begin
        ok = 1'b0;
        $display("FAIL wr_strobe: got ready=%b held=%b, expected ready=1 held=0", ddr3_ready, prev_wr);
      end
      if (!ok) fails++;
    end
    if (sdram_rd) begin
      rd_count++;
      tests++;
      if (!sdram_ready || prev_rd) begin
        fails++;
        $display("FAIL rd_strobe: got ready=%b held=%b, expected ready=1 held=0", sdram_ready, prev_rd);
      end
    end
    if (done) done_count++;
    if (|blk_clean) clean_pulses++;
    clean_acc = clean_acc | blk_clean;
    if (sdram_request || ddr3_request) req_seen = 1'b1;
    prev_wr = ddr3_wr;
    prev_rd = sdram_rd;
  end

  task automatic clear_counters();
    wr_count = 0; rd_count = 0; done_count = 0; clean_pulses = 0;
    clean_acc = '0; req_seen = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_region(input int i, input logic d, input logic [24:0] sb,
                            input logic [27:0] db, input int size);
    blk_dirty[i] = d;
    blk_sdram_base[i*25 +: 25] = sb;
    blk_ddr3_base[i*28 +: 28] = db;
    blk_size[i*SIZE_W +: SIZE_W] = SIZE_W'(size);
  endtask

  task automatic push_region(input logic [24:0] sb, input logic [27:0] db, input int size);
    logic [15:0] s;
    wr_t e;
    s = '0;
    for (int i = 0; i < size; i++) begin
      e.addr = db + 28'(i);
      e.data = sbyte(sb + 25'(i));
      s = s + 16'(e.data);
      exp_q.push_back(e);
    end
`ifdef SRAM_SAVE_CHECKSUM_EN
    e.addr = db + 28'(size);     e.data = s[7:0];  exp_q.push_back(e);
    e.addr = db + 28'(size + 1); e.data = s[15:8]; exp_q.push_back(e);
`endif
  endtask

  task automatic run_pass(input int limit, output int cycles);
    save_request = 1'b1;
    @(posedge clk); #1;
    save_request = 1'b0;
    cycles = 1;
    while (!done && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected a done pulse", cycles);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, sdram_rd, ddr3_wr, sdram_request, ddr3_request, blk_clean,
         sdram_addr, ddr3_addr, ddr3_din} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b req=%b addr=%h/%h, expected all zero",
               busy, sdram_request, sdram_addr, ddr3_addr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_single_region();
    int c;
    smem[25'h100] = 8'h11; smem[25'h101] = 8'h22; smem[25'h102] = 8'h33; smem[25'h103] = 8'h44;
    set_region(0, 1'b1, 25'h100, 28'h200000, 4);
    set_region(1, 1'b0, 25'h0, 28'h0, 0);
    clear_counters();
    push_region(25'h100, 28'h200000, 4);
    run_pass(200, c);
    tests++;
    if (wr_count != 4 + CS_EXTRA || rd_count != 4) begin
      fails++;
      $display("FAIL single_count: got wr=%0d rd=%0d, expected wr=%0d rd=4", wr_count, rd_count, 4 + CS_EXTRA);
    end
    tests++;
    if (clean_acc !== 2'b01 || clean_pulses != 1) begin
      fails++;
      $display("FAIL single_clean: got acc=%b pulses=%0d, expected 01 1", clean_acc, clean_pulses);
    end
    tests++;
    if (done_count != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_end: got done=%0d busy=%b left=%0d, expected 1 0 0", done_count, busy, exp_q.size());
    end
  endtask

  task automatic test_all_clean();
    int c;
    set_region(0, 1'b0, 25'h100, 28'h200000, 4);
    set_region(1, 1'b0, 25'h0, 28'h0, 8);
    clear_counters();
    run_pass(20, c);
    tests++;
    if (c > 4) begin
      fails++;
      $display("FAIL clean_latency: got %0d cycles, expected at most 4", c);
    end
    tests++;
    if (wr_count != 0 || rd_count != 0 || req_seen || clean_acc !== '0) begin
      fails++;
      $display("FAIL clean_activity: got wr=%0d rd=%0d req=%b clean=%b, expected 0 0 0 00",
               wr_count, rd_count, req_seen, clean_acc);
    end
  endtask

  task automatic test_ready_stall();
    int c;
    set_region(0, 1'b0, 25'h0, 28'h0, 0);
    set_region(1, 1'b1, 25'h40, 28'h5000, 2);
    clear_counters();
    push_region(25'h40, 28'h5000, 2);
    fork
      run_pass(400, c);
      begin
        for (int b = 0; b < 2; b++) begin
          int w = 0;
          while (!sdram_rd && w < 100) begin
            @(posedge clk); #1;
            w++;
          end
          ddr3_ready = 1'b0;
          repeat (10) begin @(posedge clk); #1; end
          ddr3_ready = 1'b1;
          @(posedge clk); #1;
        end
      end
    join
    tests++;
    if (wr_count != 2 + CS_EXTRA || exp_q.size() != 0 || c < 20) begin
      fails++;
      $display("FAIL stall_writes: got wr=%0d left=%0d cycles=%0d, expected wr=%0d left=0 cycles>=20",
               wr_count, exp_q.size(), c, 2 + CS_EXTRA);
    end
    tests++;
    if (clean_acc !== 2'b10) begin
      fails++;
      $display("FAIL stall_clean: got %b, expected 10", clean_acc);
    end
  endtask

  task automatic test_zero_size();
    int c;
    set_region(0, 1'b1, 25'h100, 28'h200000, 0);
    set_region(1, 1'b0, 25'h0, 28'h0, 4);
    clear_counters();
    run_pass(20, c);
    tests++;
    if (clean_acc !== 2'b00 || wr_count != 0 || rd_count != 0 || req_seen) begin
      fails++;
      $display("FAIL zero_size: got clean=%b wr=%0d rd=%0d req=%b, expected 00 0 0 0",
               clean_acc, wr_count, rd_count, req_seen);
    end
  endtask

  task automatic test_wrap_and_ignore();
    int c;
    set_region(0, 1'b0, 25'h0, 28'h0, 0);
    set_region(1, 1'b1, 25'h1FFFFFE, 28'hFFFFFFE, 3);
    clear_counters();
    push_region(25'h1FFFFFE, 28'hFFFFFFE, 3);
    fork
      run_pass(200, c);
      begin
        repeat (5) begin @(posedge clk); #1; end
        save_request = 1'b1;
        @(posedge clk); #1;
        save_request = 1'b0;
      end
    join
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if (wr_count != 3 + CS_EXTRA || exp_q.size() != 0 || clean_acc !== 2'b10) begin
      fails++;
      $display("FAIL wrap_writes: got wr=%0d left=%0d clean=%b, expected wr=%0d left=0 clean=10",
               wr_count, exp_q.size(), clean_acc, 3 + CS_EXTRA);
    end
    tests++;
    if (done_count != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore: got done=%0d busy=%b, expected 1 0", done_count, busy);
    end
  endtask

  task automatic test_reset_mid_pass();
    int c;
    int w = 0;
    set_region(0, 1'b1, 25'h400, 28'h300, 16);
    set_region(1, 1'b0, 25'h0, 28'h0, 0);
    clear_counters();
    push_region(25'h400, 28'h300, 16);
    save_request = 1'b1;
    @(posedge clk); #1;
    save_request = 1'b0;
    while (wr_count < 2 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({busy, done, sdram_rd, ddr3_wr, sdram_request, ddr3_request, blk_clean,
         sdram_addr, ddr3_addr, ddr3_din} !== '0 || wr_count != 2) begin
      fails++;
      $display("FAIL abort_outputs: got busy=%b req=%b addr=%h/%h wr=%0d, expected zeros and wr=2",
               busy, sdram_request, sdram_addr, ddr3_addr, wr_count);
    end
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (done_count != 0 || clean_acc !== '0) begin
      fails++;
      $display("FAIL abort_pulses: got done=%0d clean=%b, expected 0 00", done_count, clean_acc);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    clear_counters();
    push_region(25'h400, 28'h300, 16);
    run_pass(500, c);
    tests++;
    if (wr_count != 16 + CS_EXTRA || exp_q.size() != 0 || clean_acc !== 2'b01) begin
      fails++;
      $display("FAIL restart: got wr=%0d left=%0d clean=%b, expected wr=%0d left=0 clean=01",
               wr_count, exp_q.size(), clean_acc, 16 + CS_EXTRA);
    end
  endtask

`ifdef SRAM_SAVE_CHECKSUM_EN
  task automatic test_checksum();
    int c;
    wr_t e;
    smem[25'h2000] = 8'hFF; smem[25'h2001] = 8'hFF; smem[25'h2002] = 8'h01;
    set_region(0, 1'b1, 25'h2000, 28'h1000, 3);
    set_region(1, 1'b0, 25'h0, 28'h0, 0);
    clear_counters();
    e.addr = 28'h1000; e.data = 8'hFF; exp_q.push_back(e);
    e.addr = 28'h1001; e.data = 8'hFF; exp_q.push_back(e);
    e.addr = 28'h1002; e.data = 8'h01; exp_q.push_back(e);
    e.addr = 28'h1003; e.data = 8'hFF; exp_q.push_back(e);
    e.addr = 28'h1004; e.data = 8'h01; exp_q.push_back(e);
    run_pass(200, c);
    tests++;
    if (wr_count != 5 || exp_q.size() != 0 || clean_acc !== 2'b01) begin
      fails++;
      $display("FAIL checksum: got wr=%0d left=%0d clean=%b, expected 5 0 01", wr_count, exp_q.size(), clean_acc);
    end
  endtask
`endif

  initial begin
    clear_counters();
    test_reset();
    test_single_region();
    test_all_clean();
    test_ready_stall();
    test_zero_size();
    test_wrap_and_ignore();
    test_reset_mid_pass();
`ifdef SRAM_SAVE_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
